video_frame_writer: RTL and testbench
=====================================

VIDEO_FRAME_WRITER -- requirements
Module: video_frame_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port as_address, input, 2 bits: register select.
REQ-004 SHALL have ports as_write and as_read, inputs, 1 bit each, plus as_writedata, input, 32 bits, and as_readdata, output, 32 bits, with read latency 1.
REQ-005 SHALL have pix_data, input, 16 bits (RGB565), pix_valid, input, 1 bit, and pix_sof, input, 1 bit: camera stream with no backpressure.
REQ-006 SHALL have am_address, output, 32 bits, am_write, output, 1 bit, am_writedata, output, 32 bits, and am_waitrequest, input, 1 bit: Avalon-MM write master to HPS SDRAM.
REQ-007 SHALL have irq, output, 1 bit: level interrupt.
REQ-008 SHALL have parameter FIFO_DEPTH, default 16: word FIFO depth (power of 2).

Function
REQ-009 SHALL decode registers as follows:
- 0 BUF_ADDR[31:0], with bits [1:0] forced to 0.
- 1 PIXEL_COUNT[23:0], with bit 0 forced to 0.
- 2 CTRL: bit0 start (write-only, self-clearing), bit1 irq_en.
- 3 STATUS: bit0 busy, bit1 done, bit2 overflow (read-only); writing 1 to bit1 clears done, writing 1 to bit2 clears overflow.
REQ-010 SHALL let software write BUF_ADDR and PIXEL_COUNT only while not busy; writes while busy are ignored.
REQ-011 SHALL implement the FSM states IDLE, WAIT_SOF, CAPTURE, DRAIN.
REQ-012 IDLE -> WAIT_SOF on start=1: latch the address pointer = BUF_ADDR, set words_left = PIXEL_COUNT/2, clear done and overflow, set busy=1.
REQ-013 SHALL, if PIXEL_COUNT=0 at start, go IDLE -> IDLE, set done=1 on the next cycle, and issue no writes.
REQ-014 WAIT_SOF: discard pixels without pix_sof. A beat with pix_valid&pix_sof is pixel 0 and moves the FSM to CAPTURE.
REQ-015 CAPTURE SHALL pack pixels in pairs: the even pixel goes to [15:0], the odd pixel to [31:16]. The word is pushed to the FIFO on the odd-pixel cycle.
REQ-016 SHALL treat pix_sof during CAPTURE as ordinary data.
REQ-017 CAPTURE -> DRAIN once PIXEL_COUNT pixels have been accepted; further pixels are discarded.
REQ-018 FIFO full on a push: drop the word, set overflow=1 (sticky), and still count the word toward words_left. Push and pop in the same cycle SHALL both succeed.
REQ-019 Master: assert am_write whenever the FIFO is non-empty and words_left>0, with am_writedata = FIFO head. am_address, am_writedata and am_write SHALL stay stable while am_waitrequest=1.
REQ-020 A transfer is accepted when am_write=1 and am_waitrequest=0. On acceptance: pop the FIFO, am_address += 4, words_left -= 1.
REQ-021 A dropped word SHALL still advance am_address by 4 without a write, so that frame geometry is preserved.
REQ-022 DRAIN -> IDLE when words_left reaches 0 and the FIFO is empty: set busy=0 and done=1.
REQ-023 SHALL drive irq = done & irq_en. irq SHALL deassert the cycle after done is cleared or irq_en is cleared.
REQ-024 SHALL ignore start while busy.
REQ-025 A STATUS write clearing done in the same cycle that done is set: set SHALL win.
REQ-026 as_readdata SHALL be valid one cycle after as_read; unused bits read 0.

Reset
REQ-027 On reset=1 at a clock edge, SHALL set: FSM=IDLE, all registers=0, FIFO empty, am_write=0, am_address=0, am_writedata=0, irq=0, as_readdata=0.
REQ-028 Reset mid-frame SHALL abort immediately: am_write drops on the next cycle and no further writes are issued.

Verification
REQ-029 Basic frame: BUF_ADDR=0x3000_0000, PIXEL_COUNT=8, start, SOF then pixels 0x0001..0x0008 -> 4 writes: 0x0002_0001@0x3000_0000 … 0x0008_0007@0x3000_000C; then done=1, busy=0.
REQ-030 Waitrequest: hold am_waitrequest=1 for 5 cycles on the 2nd write -> address/data stable throughout; exactly 4 writes total.
REQ-031 Pre-SOF pixels: 3 pixels before SOF are discarded; the first stored word starts at the SOF pixel.
REQ-032 Overflow: FIFO_DEPTH=4, am_waitrequest=1 held for a 12-pixel frame -> overflow=1; released writes land at the correct addresses, skipping dropped words; done=1.
REQ-033 IRQ and zero-length: irq_en=1, PIXEL_COUNT=0, start -> done=1 and irq=1 with no writes; STATUS write 0x2 -> irq=0 one cycle later.
REQ-034 Reset and start-while-busy: assert reset after 2 words of a 16-pixel frame -> am_write=0 and STATUS=0 next cycle. A start issued while busy leaves BUF_ADDR and the write stream unchanged.

Source files
------------

// File: rtl/video_frame_writer.sv
// Camera-to-SDRAM frame writer: packs RGB565 pixel pairs into 32-bit words and
// streams them through a small FIFO to an Avalon-MM write master.
module video_frame_writer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  as_address,
  input  logic        as_write,
  input  logic        as_read,
  input  logic [31:0] as_writedata,
  output logic [31:0] as_readdata,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [31:0] am_address,
  output logic        am_write,
  output logic [31:0] am_writedata,
  input  logic        am_waitrequest,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [23:0] pix_count_q, pix_count_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] push_addr_q, push_addr_d;
  logic [22:0] words_left_q, words_left_d;
  logic [23:0] pix_idx_q, pix_idx_d;
  logic [15:0] low_q, low_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Each FIFO entry carries its own target address so words queued behind a
  // dropped word still land at their true position in the frame.
  logic [31:0] fifo_addr_mem [FIFO_DEPTH];
  logic [31:0] fifo_data_mem [FIFO_DEPTH];

  logic busy, start, fifo_empty, fifo_full, accept, push, push_ok, drop;

  assign busy       = (state_q != S_IDLE);
  assign start      = as_write && (as_address == 2'd2) && as_writedata[0] && !busy;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign am_write   = !fifo_empty && (words_left_q != '0);
  assign accept     = am_write && !am_waitrequest;
  assign push       = (state_q == S_CAPTURE) && pix_valid && pix_idx_q[0];
  assign push_ok    = push && (!fifo_full || accept);
  assign drop       = push && !push_ok;

  assign am_address   = fifo_empty ? '0 : fifo_addr_mem[rd_ptr_q[AW-1:0]];
  assign am_writedata = fifo_empty ? '0 : fifo_data_mem[rd_ptr_q[AW-1:0]];
  assign as_readdata  = rdata_q;
  assign irq          = irq_q;

  always_comb begin
    state_d      = state_q;
    buf_addr_d   = buf_addr_q;
    pix_count_d  = pix_count_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    rdata_d      = rdata_q;
    push_addr_d  = push_addr_q;
    words_left_d = words_left_q;
    pix_idx_d    = pix_idx_q;
    low_d        = low_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (as_write && !busy && as_address == 2'd0) buf_addr_d = {as_writedata[31:2], 2'b00};
    if (as_write && !busy && as_address == 2'd1) pix_count_d = {as_writedata[23:1], 1'b0};
    if (as_write && as_address == 2'd2) irq_en_d = as_writedata[1];
    if (as_write && as_address == 2'd3) begin
      if (as_writedata[1]) done_d = 1'b0;
      if (as_writedata[2]) ovf_d = 1'b0;
    end

    if (push) push_addr_d = push_addr_q + 32'd4;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (accept || drop) words_left_d = words_left_q - 23'd1;
    if (drop) ovf_d = 1'b1;

    // Status sets are applied after the software clears so a set wins.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d  = 1'b0;
          done_d = (pix_count_q == '0);
          if (pix_count_q != '0) begin
            state_d      = S_WAIT_SOF;
            push_addr_d  = buf_addr_q;
            words_left_d = pix_count_q[23:1];
          end
        end
      end
      S_WAIT_SOF: begin
        if (pix_valid && pix_sof) begin
          low_d     = pix_data;
          pix_idx_d = 24'd1;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          if (!pix_idx_q[0]) low_d = pix_data;
          pix_idx_d = pix_idx_q + 24'd1;
          if (pix_idx_d == pix_count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (words_left_q == '0 && fifo_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (as_read) begin
      case (as_address)
        2'd0:    rdata_d = buf_addr_q;
        2'd1:    rdata_d = {8'd0, pix_count_q};
        2'd2:    rdata_d = {30'd0, irq_en_q, 1'b0};
        default: rdata_d = {29'd0, ovf_q, done_q, busy};
      endcase
    end

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      buf_addr_q   <= '0;
      pix_count_q  <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
      push_addr_q  <= '0;
      words_left_q <= '0;
      pix_idx_q    <= '0;
      low_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      buf_addr_q   <= buf_addr_d;
      pix_count_q  <= pix_count_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      push_addr_q  <= push_addr_d;
      words_left_q <= words_left_d;
      pix_idx_q    <= pix_idx_d;
      low_q        <= low_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr_mem[wr_ptr_q[AW-1:0]] <= push_addr_q;
      fifo_data_mem[wr_ptr_q[AW-1:0]] <= {pix_data, low_q};
    end
  end

endmodule

// File: tb/tb_video_frame_writer.sv
// Bench for video_frame_writer: directed and randomized frames checked against
// a frame-level model (word k = {pix[2k+1], pix[2k]} at base + 4k).
module tb_video_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  as_address;
  logic        as_write, as_read;
  logic [31:0] as_writedata, as_readdata;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof;
  logic [31:0] am_address, am_writedata;
  logic        am_write, am_waitrequest;
  logic        irq;

  video_frame_writer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .as_address(as_address), .as_write(as_write), .as_read(as_read),
    .as_writedata(as_writedata), .as_readdata(as_readdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .am_address(am_address), .am_write(am_write), .am_writedata(am_writedata),
    .am_waitrequest(am_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int wr_mode = 0;
  int hold_cnt = 0;
  int free_run = 0;
  int stall_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    as_address = a; as_writedata = d; as_write = 1'b1;
    step();
    as_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    as_address = a; as_read = 1'b1;
    step();
    as_read = 1'b0;
    d = as_readdata;
  endtask

  task automatic drive_pix(input logic [15:0] d, input logic v, input logic s);
    pix_data = d; pix_valid = v; pix_sof = s;
    step();
  endtask

  // Slave model: 0 ready, 1 short random stalls, 2 stall always, 3 stall 5 cycles on 2nd write
  initial begin
    am_waitrequest = 1'b0;
    forever begin
      step();
      case (wr_mode)
        1: begin
          if (stall_len > 0) begin
            am_waitrequest = 1'b1; stall_len--; free_run = 0;
          end else if (free_run >= 3 && $urandom_range(0, 3) == 0) begin
            am_waitrequest = 1'b1; stall_len = $urandom_range(0, 1); free_run = 0;
          end else begin
            am_waitrequest = 1'b0; free_run++;
          end
        end
        2: am_waitrequest = 1'b1;
        3: begin
          if (mon_addr.size() == 1 && am_write && hold_cnt < 5) begin
            am_waitrequest = 1'b1; hold_cnt++;
          end else am_waitrequest = 1'b0;
        end
        default: begin am_waitrequest = 1'b0; hold_cnt = 0; end
      endcase
    end
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_a, prev_d;
  always @(negedge clk) begin
    if (!reset && prev_stall) begin
      check("hold_write", {31'd0, am_write}, 32'd1);
      check("hold_addr", am_address, prev_a);
      check("hold_data", am_writedata, prev_d);
    end
    if (!reset && am_write && !am_waitrequest) begin
      mon_addr.push_back(am_address);
      mon_data.push_back(am_writedata);
    end
    prev_stall = !reset && am_write && am_waitrequest;
    prev_a = am_address;
    prev_d = am_writedata;
  end

  task automatic run_frame(input logic [31:0] base, input int n, input int pre,
                           input bit seq, input int wmode, input bit poke);
    logic [15:0] pix[$];
    logic [31:0] rd;
    int nexp, guard;
    bit ovf_exp;
    mon_addr.delete();
    mon_data.delete();
    wr_mode = wmode;
    bus_write(2'd0, base);
    bus_write(2'd1, n);
    bus_write(2'd2, 32'h1);
    if (poke) begin
      bus_write(2'd0, ~base & 32'hFFFF_FFFC);
      bus_write(2'd1, 32'd4);
      bus_write(2'd2, 32'h1);
      bus_read(2'd0, rd);
      check("busy_bufaddr", rd, base);
      bus_read(2'd1, rd);
      check("busy_pixcount", rd, n);
    end
    for (int i = 0; i < n; i++) pix.push_back(seq ? 16'(i + 1) : 16'($urandom));
    for (int i = 0; i < pre; i++) drive_pix(16'($urandom), 1'b1, 1'b0);
    drive_pix(pix[0], 1'b1, 1'b1);
    for (int i = 1; i < n; i++) begin
      repeat ($urandom_range(0, 1)) drive_pix(16'($urandom), 1'b0, $urandom_range(0, 1) == 0);
      drive_pix(pix[i], 1'b1, $urandom_range(0, 3) == 0);
    end
    repeat (3) drive_pix(16'($urandom), 1'b1, $urandom_range(0, 1) == 0);
    pix_valid = 1'b0; pix_sof = 1'b0;
    if (wmode == 2) begin
      repeat (4) step();
      wr_mode = 0;
    end
    guard = 0;
    rd = '0;
    while (!rd[1] && guard < 300) begin
      bus_read(2'd3, rd);
      guard++;
    end
    nexp = n / 2;
    ovf_exp = 1'b0;
    if (wmode == 2 && nexp > 4) begin nexp = 4; ovf_exp = 1'b1; end
    check("status_end", rd, {29'd0, ovf_exp, 2'b10});
    check("write_count", mon_addr.size(), nexp);
    for (int k = 0; k < nexp && k < mon_addr.size(); k++) begin
      check("wr_addr", mon_addr[k], base + 4 * k);
      check("wr_data", mon_data[k], {pix[2*k+1], pix[2*k]});
    end
    wr_mode = 0;
  endtask

  initial begin
    logic [31:0] rd, rb;
    int nw;
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd, rb;
    int nw;
    reset = 1'b1; as_address = '0; as_write = 1'b0; as_read = 1'b0; as_writedata = '0;
    pix_data = '0; pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (2) step();
    check("rst_am_write", {31'd0, am_write}, 32'd0);
    check("rst_am_address", am_address, 32'd0);
    check("rst_am_writedata", am_writedata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", as_readdata, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check("rst_reg", rd, 32'd0);
    end

    bus_write(2'd0, 32'h1234_5677);
    bus_read(2'd0, rd);
    check("bufaddr_align", rd, 32'h1234_5674);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    check("pixcount_mask", rd, 32'h00FF_FFFE);
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, rd);
    check("ctrl_read", rd, 32'h2);
    bus_write(2'd2, 32'h0);

    run_frame(32'h3000_0000, 8, 0, 1'b1, 0, 1'b0);
    check("basic_first", mon_data[0], 32'h0002_0001);
    check("basic_last_addr", mon_addr[3], 32'h3000_000C);

    run_frame(32'h3000_0100, 8, 0, 1'b1, 3, 1'b0);
    check("stall_cycles", hold_cnt, 32'd5);

    run_frame(32'h3000_0200, 8, 3, 1'b1, 0, 1'b0);
    check("presof_first", mon_data[0], 32'h0002_0001);

    run_frame(32'h3000_0400, 12, 0, 1'b1, 2, 1'b0);

    bus_write(2'd2, 32'h2);
    bus_write(2'd1, 32'd0);
    nw = mon_addr.size();
    bus_write(2'd2, 32'h3);
    check("zero_irq_set", {31'd0, irq}, 32'd1);
    bus_read(2'd3, rd);
    check("zero_status", rd, 32'h2);
    check("zero_irq_held", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h2);
    check("zero_irq_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check("zero_status_clr", rd, 32'h0);
    bus_write(2'd2, 32'h3);
    check("irq_en_set", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h0);
    check("irq_en_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check("irq_en_done_kept", rd, 32'h2);
    check("zero_no_writes", mon_addr.size(), nw);

    run_frame(32'h3000_0800, 10, 1, 1'b0, 1, 1'b1);

    for (int f = 0; f < 6; f++) begin
      rb = $urandom;
      rb[1:0] = 2'b00;
      run_frame(rb, 2 * $urandom_range(1, 12), $urandom_range(0, 4), 1'b0, 1, $urandom_range(0, 1) == 1);
    end

    mon_addr.delete();
    mon_data.delete();
    wr_mode = 0;
    bus_write(2'd0, 32'h4000_0000);
    bus_write(2'd1, 32'd16);
    bus_write(2'd2, 32'h1);
    drive_pix(16'h1111, 1'b1, 1'b1);
    for (int i = 1; i < 16 && mon_addr.size() < 2; i++) drive_pix(16'(i), 1'b1, 1'b0);
    check("pre_reset_writes", mon_addr.size(), 32'd2);
    reset = 1'b1;
    step();
    check("reset_am_write", {31'd0, am_write}, 32'd0);
    check("reset_am_address", am_address, 32'd0);
    reset = 1'b0;
    repeat (10) drive_pix(16'($urandom), 1'b1, $urandom_range(0, 1) == 0);
    pix_valid = 1'b0; pix_sof = 1'b0;
    bus_read(2'd3, rd);
    check("reset_status", rd, 32'd0);
    bus_read(2'd0, rd);
    check("reset_bufaddr", rd, 32'd0);
    check("reset_no_writes", mon_addr.size(), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
